// File: rtl/pulse_voice_generator_if.sv
// Sequencer-to-voice bus: note/duty/envelope inputs and the sample/status outputs.
// The sequencer side uses the master modport, the voice the slave modport.
interface pulse_voice_generator_if;
    logic        i_sample_stb;
    logic [31:0] i_phase_delta;
    logic [7:0]  i_top;
    logic        i_top_valid;
    logic [8:0]  i_envelope;
    logic [15:0] o_sample;
    logic        o_sample_valid;
    logic        o_busy;
    logic        o_overrun;
    logic [31:0] o_phase;

    modport master (
        output i_sample_stb, i_phase_delta, i_top, i_top_valid, i_envelope,
        input  o_sample, o_sample_valid, o_busy, o_overrun, o_phase
    );

    modport slave (
        input  i_sample_stb, i_phase_delta, i_top, i_top_valid, i_envelope,
        output o_sample, o_sample_valid, o_busy, o_overrun, o_phase
    );
endinterface

// File: rtl/pulse_voice_generator.sv
// Pulse-wave voice: phase accumulator with duty threshold, envelope scaled by GAIN
// via a 9-cycle serial shift-add multiply, signed sample out with fixed latency.
module pulse_voice_generator #(
    parameter logic [6:0] GAIN = 7'd64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    pulse_voice_generator_if.slave   io_voice
);
    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

    state_t      r_state;
    logic [3:0]  r_bit_cnt;
    logic [8:0]  r_env;
    logic [15:0] r_mcand;
    logic [15:0] r_prod;
    logic        r_polarity;
    logic [7:0]  r_top;
    logic [31:0] r_phase;
    logic [15:0] r_sample;
    logic        r_valid;
    logic        r_busy;
    logic        r_overrun;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_env      <= '0;
            r_mcand    <= '0;
            r_prod     <= '0;
            r_polarity <= 1'b0;
            r_top      <= 8'h80;
            r_phase    <= '0;
            r_sample   <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (io_voice.i_top_valid)
                r_top <= io_voice.i_top;
            if (io_voice.i_sample_stb && (r_state != IDLE))
                r_overrun <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (io_voice.i_sample_stb) begin
                        r_polarity <= (r_phase[31:24] < r_top);
                        r_env      <= io_voice.i_envelope;
                        r_mcand    <= {9'd0, GAIN};
                        r_prod     <= '0;
                        r_phase    <= r_phase + io_voice.i_phase_delta;
                        r_bit_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= MULT;
                    end
                end
                MULT: begin
                    // LSB-first: multiplicand doubles as each envelope bit is consumed
                    if (r_env[0])
                        r_prod <= r_prod + r_mcand;
                    r_env   <= r_env >> 1;
                    r_mcand <= r_mcand << 1;
                    if (r_bit_cnt == 4'd8)
                        r_state <= DONE;
                    else
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                DONE: begin
                    r_sample <= r_polarity ? r_prod : (~r_prod + 16'd1);
                    r_valid  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_voice.o_sample       = r_sample;
    assign io_voice.o_sample_valid = r_valid;
    assign io_voice.o_busy         = r_busy;
    assign io_voice.o_overrun      = r_overrun;
    assign io_voice.o_phase        = r_phase;
endmodule

// File: doc/pulse_voice_generator.md
PULSE_VOICE_GENERATOR -- requirements
Module: pulse_voice_generator

Interface
REQ-001 SHALL have parameter GAIN, default 64, unsigned 7-bit amplitude multiplier; legal range 0..64.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_sample_stb  input  1  single-cycle audio sample-rate strobe.
REQ-005 SHALL have port i_phase_delta  input  32  per-sample phase increment from the channel note sequencer.
REQ-006 SHALL have port i_top  input  8  duty threshold from the sequencer.
REQ-007 SHALL have port i_top_valid  input  1  qualifies i_top.
REQ-008 SHALL have port i_envelope  input  9  unsigned amplitude from the sequencer.
REQ-009 SHALL have port o_sample  output  16  signed two's-complement voice sample.
REQ-010 SHALL have port o_sample_valid  output  1  single-cycle strobe marking a new o_sample.
REQ-011 SHALL have port o_busy  output  1  high while a sample computation is in progress.
REQ-012 SHALL have port o_overrun  output  1  sticky flag for a strobe dropped while busy.
REQ-013 SHALL have port o_phase  output  32  current phase accumulator value.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, MULT, DONE.
REQ-015 In IDLE with i_sample_stb high, the block SHALL, in the same cycle, perform all of the following:
- capture polarity = (o_phase[31:24] < top_reg), using the pre-update phase;
- capture i_envelope;
- update o_phase <= o_phase + i_phase_delta, modulo 2^32;
- enter MULT with bit counter 0.
REQ-016 top_reg SHALL load i_top on any cycle with i_top_valid high, independent of FSM state; otherwise it holds.
REQ-017 MULT SHALL compute the 16-bit unsigned product envelope*GAIN by serial shift-add, one multiplier bit per cycle, for exactly 9 cycles (counter 0..8), then enter DONE.
REQ-018 DONE SHALL last one cycle, during which:
- o_sample = +product if polarity is 1, else -product;
- o_sample_valid = 1;
- the FSM returns to IDLE.
REQ-019 Latency SHALL be fixed: o_sample_valid is high in the 11th cycle after the cycle in which the accepted i_sample_stb was high.
REQ-020 o_sample SHALL hold its value between o_sample_valid pulses.
REQ-021 o_busy SHALL be high in MULT and DONE, and low in IDLE.
REQ-022 An i_sample_stb arriving while in MULT or DONE SHALL be ignored (no phase update) and SHALL set o_overrun, which stays set until reset.
REQ-023 Envelope 0 or GAIN 0 SHALL yield o_sample = 0, regardless of polarity.
REQ-024 Duty boundaries:
- top_reg = 0 SHALL give polarity 0 always;
- top_reg = 255 SHALL give polarity 1 except when o_phase[31:24] = 255.
REQ-025 i_phase_delta = 0 SHALL freeze o_phase; the output is then a constant-polarity level.
REQ-026 Inputs i_phase_delta and i_envelope SHALL be sampled only on accepted strobes; changes mid-computation SHALL NOT affect the current sample.

Reset
REQ-027 On i_rst high, the following values SHALL be set:
- FSM = IDLE;
- o_phase = 0;
- o_sample = 0;
- o_sample_valid = 0;
- o_busy = 0;
- o_overrun = 0;
- top_reg = 8'h80.
REQ-028 Reset asserted mid-MULT or mid-DONE SHALL abort the computation; no o_sample_valid is produced for it.
REQ-029 i_rst SHALL take priority over i_sample_stb and i_top_valid in the same cycle.

Verification
REQ-030 Reset check:
- stimulus: hold i_rst for 2 cycles, then release;
- required response: all outputs 0, o_phase = 0; first strobe with delta 0 and top not loaded gives polarity 1 (0 < 0x80).
REQ-031 Square-wave check (GAIN = 64, delta = 0x0100_0000, top = 0x80, env = 14):
- strobes 1..128 SHALL yield +896;
- strobes 129..256 SHALL yield -896;
- each o_sample_valid SHALL arrive exactly 11 cycles after its strobe.
REQ-032 Wrap check (delta = 0x8000_0000, top = 0x80, env = 511):
- samples SHALL alternate +32704, -32704;
- o_phase SHALL alternate 0x8000_0000, 0x0000_0000.
REQ-033 Zero-envelope check (env = 0, any phase and top): o_sample SHALL be 0 on every valid.
REQ-034 Overrun check:
- stimulus: second strobe 4 cycles after the first;
- required response: exactly one o_sample_valid, o_phase advanced once, o_overrun = 1 until the next reset.
REQ-035 Reset-abort check:
- stimulus: assert i_rst 5 cycles after a strobe;
- required response: no o_sample_valid; o_busy = 0 and o_sample = 0 on the cycle after reset.
